// File: rtl/ascon_block_packer.sv
// rtl/ascon_block_packer.sv - packs a 32-bit AD/message word stream into padded 128-bit Ascon rate blocks
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   in_valid      input word valid
//   in_ready      packer accepts a word this cycle (decoded from FSM state only)
//   in_data       input bytes, byte j at [8j+7:8j], byte 0 earliest
//   in_bytes      valid bytes in the word (0..4, low-aligned)
//   in_last       word closes the segment
//   in_type       0 = associated data, 1 = message; sampled on the segment's first word
//   blk_valid     output block valid
//   blk_ready     consumer accepts the block
//   blk_data      packed block; lane 0 = [127:64], lane 1 = [63:0], little-endian lanes
//   blk_bytes     real (unpadded) bytes in the block, 0..16
//   blk_first     first block of the segment
//   blk_last      last block of the segment (carries the 0x01 pad byte)
//   blk_type      segment type latched from in_type
//   err           sticky protocol-violation flag

module ascon_block_packer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic [2:0]   in_bytes,
    input  logic         in_last,
    input  logic         in_type,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [127:0] blk_data,
    output logic [4:0]   blk_bytes,
    output logic         blk_first,
    output logic         blk_last,
    output logic         blk_type,
    output logic         err
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EMIT = 2'd1,
        PAD  = 2'd2
    } state_t;

    // Padding-only block: 0x01 in block byte 0 (lane 0, bits [71:64]).
    localparam logic [127:0] PAD_BLOCK = {56'd0, 8'h01, 64'd0};

    state_t         state_q;
    state_t         state_d;

    logic [127:0]   buf_q;
    logic [4:0]     n_q;
    logic           pad_pending_q;
    logic           seg_first_q;     // next emitted block opens a segment
    logic           word_first_q;    // next accepted word opens a segment
    logic [4:0]     bytes_q;
    logic           first_q;
    logic           last_q;
    logic           type_q;
    logic           err_q;

    logic           accept;
    logic           blk_xfer;
    logic [2:0]     eff_bytes;
    logic [4:0]     sum;
    logic [4:0]     n_final;
    logic           block_done;
    logic           violation;
    logic [127:0]   wr_buf;
    logic [4:0]     pos;

    // Bit offset of block byte k: lane 0 sits in the upper half, so the lane
    // bit is inverted; within a lane bytes are little-endian.
    function automatic logic [6:0] bit_off(input logic [3:0] k);
        return {~k[3], k[2:0], 3'b000};
    endfunction

    assign accept    = in_valid && (state_q == FILL);
    assign blk_xfer  = blk_ready && (state_q != FILL);

    // Oversized words are clamped to four bytes; the error flag records them.
    assign eff_bytes = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    assign sum       = n_q + {2'b00, eff_bytes};
    // After a violation n can be unaligned; bytes beyond 16 are dropped.
    assign n_final   = (sum > 5'd16) ? 5'd16 : sum;
    assign block_done = (n_final == 5'd16) || in_last;
    assign violation = (in_bytes > 3'd4) || ((in_bytes != 3'd4) && !in_last);

    // Merge the incoming bytes into the buffer and, on a short final block,
    // drop the 0x01 pad byte at the first free position. Bytes above n are
    // already zero because the buffer is cleared between blocks.
    always_comb begin
        wr_buf = buf_q;
        pos    = 5'd0;
        for (int i = 0; i < 4; i++) begin
            pos = n_q + 5'(i);
            if ((3'(i) < eff_bytes) && (pos < 5'd16)) begin
                wr_buf[bit_off(pos[3:0]) +: 8] = in_data[8*i +: 8];
            end
        end
        if (in_last && (n_final < 5'd16)) begin
            wr_buf[bit_off(n_final[3:0]) +: 8] = 8'h01;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: if (accept && block_done) state_d = EMIT;
            EMIT: if (blk_ready) state_d = pad_pending_q ? PAD : FILL;
            PAD:  if (blk_ready) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // FSM output decode: depends on the state register only.
    always_comb begin
        in_ready  = 1'b0;
        blk_valid = 1'b0;
        case (state_q)
            FILL:    in_ready  = 1'b1;
            EMIT:    blk_valid = 1'b1;
            PAD:     blk_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Datapath and block descriptor registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q         <= '0;
            n_q           <= '0;
            pad_pending_q <= 1'b0;
            seg_first_q   <= 1'b1;
            word_first_q  <= 1'b1;
            bytes_q       <= '0;
            first_q       <= 1'b0;
            last_q        <= 1'b0;
            type_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            if (accept) begin
                buf_q        <= wr_buf;
                n_q          <= n_final;
                word_first_q <= in_last;
                if (word_first_q) begin
                    type_q <= in_type;
                end
                if (violation) begin
                    err_q <= 1'b1;
                end
                if (block_done) begin
                    bytes_q       <= n_final;
                    first_q       <= seg_first_q;
                    // A last word that exactly fills the block defers the pad
                    // byte to a separate padding-only block.
                    last_q        <= in_last && (n_final < 5'd16);
                    pad_pending_q <= in_last && (n_final == 5'd16);
                end
            end

            if (blk_xfer) begin
                seg_first_q <= last_q;
                if ((state_q == EMIT) && pad_pending_q) begin
                    buf_q   <= PAD_BLOCK;
                    bytes_q <= 5'd0;
                    first_q <= 1'b0;
                    last_q  <= 1'b1;
                end else begin
                    buf_q         <= '0;
                    n_q           <= '0;
                    pad_pending_q <= 1'b0;
                end
            end
        end
    end

    assign blk_data  = buf_q;
    assign blk_bytes = bytes_q;
    assign blk_first = first_q;
    assign blk_last  = last_q;
    assign blk_type  = type_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ascon_block_packer.sv
// tb/tb_ascon_block_packer.sv - directed self-checking bench for ascon_block_packer

module tb_ascon_block_packer;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [2:0]   in_bytes;
    logic         in_last;
    logic         in_type;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] blk_data;
    logic [4:0]   blk_bytes;
    logic         blk_first;
    logic         blk_last;
    logic         blk_type;
    logic         err;

    int total;
    int bad;

    logic [127:0] cap_data;
    logic [4:0]   cap_bytes;
    logic         cap_first;
    logic         cap_last;
    logic         cap_type;
    logic         got;
    logic         sent;

    ascon_block_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bytes  (in_bytes),
        .in_last   (in_last),
        .in_type   (in_type),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_bytes (blk_bytes),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .blk_type  (blk_type),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_word(input logic [31:0] d, input logic [2:0] nb,
                             input logic last, input logic typ, output logic ok);
        ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_bytes = nb;
        in_last  = last;
        in_type  = typ;
        for (int k = 0; k < 50; k++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic recv_block(output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (blk_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            cap_data  = blk_data;
            cap_bytes = blk_bytes;
            cap_first = blk_first;
            cap_last  = blk_last;
            cap_type  = blk_type;
            blk_ready = 1'b1;
            @(posedge clk);
            #1;
            blk_ready = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || blk_valid !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: in_ready=%b blk_valid=%b err=%b required 1 0 0", in_ready, blk_valid, err);
        end
        total++;
        if (blk_data !== 128'd0 || blk_bytes !== 5'd0 || blk_first !== 1'b0 ||
            blk_last !== 1'b0 || blk_type !== 1'b0) begin
            bad++;
            $display("FAIL reset_blk: data=%h bytes=%0d first=%b last=%b type=%b required all zero",
                     blk_data, blk_bytes, blk_first, blk_last, blk_type);
        end
    endtask

    task automatic test_ad_segment();
        for (int w = 0; w < 4; w++) begin
            send_word({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, 3'd4, 1'b0, 1'b0, sent);
        end
        total++;
        if (blk_valid !== 1'b1) begin
            bad++;
            $display("FAIL ad_valid_latency: blk_valid=%b required 1", blk_valid);
        end
        recv_block(got);
        total++;
        if (!got || cap_data !== {64'h0706050403020100, 64'h0F0E0D0C0B0A0908} ||
            cap_bytes !== 5'd16 || cap_first !== 1'b1 || cap_last !== 1'b0 || cap_type !== 1'b0) begin
            bad++;
            $display("FAIL ad_block1: got=%b data=%h bytes=%0d first=%b last=%b type=%b required data=0706050403020100_0f0e0d0c0b0a0908 bytes=16 first=1 last=0 type=0",
                     got, cap_data, cap_bytes, cap_first, cap_last, cap_type);
        end
        send_word(32'h13121110, 3'd4, 1'b1, 1'b0, sent);
        recv_block(got);
        total++;
        if (!got || cap_data !== {64'h0000000113121110, 64'h0} ||
            cap_bytes !== 5'd4 || cap_first !== 1'b0 || cap_last !== 1'b1 || cap_type !== 1'b0) begin
            bad++;
            $display("FAIL ad_block2: got=%b data=%h bytes=%0d first=%b last=%b type=%b required data=0000000113121110_0 bytes=4 first=0 last=1 type=0",
                     got, cap_data, cap_bytes, cap_first, cap_last, cap_type);
        end
    endtask

    task automatic test_msg_exact16();
        send_word(32'hA3A2A1A0, 3'd4, 1'b0, 1'b1, sent);
        send_word(32'hA7A6A5A4, 3'd4, 1'b0, 1'b0, sent);
        send_word(32'hABAAA9A8, 3'd4, 1'b0, 1'b0, sent);
        send_word(32'hAFAEADAC, 3'd4, 1'b1, 1'b0, sent);
        recv_block(got);
        total++;
        if (!got || cap_data !== {64'hA7A6A5A4A3A2A1A0, 64'hAFAEADACABAAA9A8} ||
            cap_bytes !== 5'd16 || cap_first !== 1'b1 || cap_last !== 1'b0 || cap_type !== 1'b1) begin
            bad++;
            $display("FAIL msg_full: got=%b data=%h bytes=%0d first=%b last=%b type=%b required data=a7a6..a0_afae..a8 bytes=16 first=1 last=0 type=1",
                     got, cap_data, cap_bytes, cap_first, cap_last, cap_type);
        end
        recv_block(got);
        total++;
        if (!got || cap_data !== {64'h0000000000000001, 64'h0} ||
            cap_bytes !== 5'd0 || cap_first !== 1'b0 || cap_last !== 1'b1 || cap_type !== 1'b1) begin
            bad++;
            $display("FAIL msg_pad: got=%b data=%h bytes=%0d first=%b last=%b type=%b required data=1_0 bytes=0 first=0 last=1 type=1",
                     got, cap_data, cap_bytes, cap_first, cap_last, cap_type);
        end
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || blk_valid !== 1'b0) begin
            bad++;
            $display("FAIL msg_back_to_fill: in_ready=%b blk_valid=%b required 1 0", in_ready, blk_valid);
        end
    endtask

    task automatic test_empty_ad();
        send_word(32'h0, 3'd0, 1'b1, 1'b0, sent);
        recv_block(got);
        total++;
        if (!got || cap_data !== {64'h1, 64'h0} || cap_bytes !== 5'd0 ||
            cap_first !== 1'b1 || cap_last !== 1'b1 || cap_type !== 1'b0) begin
            bad++;
            $display("FAIL empty_ad: got=%b data=%h bytes=%0d first=%b last=%b type=%b required data=1_0 bytes=0 first=1 last=1 type=0",
                     got, cap_data, cap_bytes, cap_first, cap_last, cap_type);
        end
    endtask

    task automatic test_backpressure();
        int unstable;
        unstable = 0;
        send_word(32'hDDCCBBAA, 3'd4, 1'b1, 1'b1, sent);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (blk_valid !== 1'b1 || in_ready !== 1'b0 ||
                blk_data !== {64'h00000001DDCCBBAA, 64'h0} || blk_bytes !== 5'd4 ||
                blk_first !== 1'b1 || blk_last !== 1'b1 || blk_type !== 1'b1) begin
                unstable++;
            end
        end
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL bp_hold: unstable_cycles=%0d required 0 (last seen valid=%b ready=%b data=%h)",
                     unstable, blk_valid, in_ready, blk_data);
        end
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
        @(negedge clk);
        total++;
        if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: blk_valid=%b in_ready=%b required 0 1", blk_valid, in_ready);
        end
    endtask

    task automatic test_error();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_pre: err=%b required 0", err);
        end
        send_word(32'h0000BBAA, 3'd2, 1'b0, 1'b0, sent);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_set: err=%b required 1", err);
        end
        send_word(32'h44332211, 3'd4, 1'b1, 1'b0, sent);
        recv_block(got);
        send_word(32'h00000055, 3'd1, 1'b1, 1'b0, sent);
        recv_block(got);
        total++;
        if (!got || err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: got=%b err=%b required got=1 err=1", got, err);
        end
    endtask

    task automatic test_reset_midblock();
        send_word(32'h11111111, 3'd4, 1'b0, 1'b1, sent);
        send_word(32'h22222222, 3'd4, 1'b0, 1'b0, sent);
        do_reset();
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || blk_valid !== 1'b0 || err !== 1'b0 || blk_data !== 128'd0 ||
            blk_bytes !== 5'd0 || blk_first !== 1'b0 || blk_last !== 1'b0 || blk_type !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_outputs: in_ready=%b valid=%b err=%b data=%h bytes=%0d first=%b last=%b type=%b required reset values",
                     in_ready, blk_valid, err, blk_data, blk_bytes, blk_first, blk_last, blk_type);
        end
        send_word(32'h00332211, 3'd3, 1'b1, 1'b0, sent);
        recv_block(got);
        total++;
        if (!got || cap_data !== {64'h0000000001332211, 64'h0} || cap_bytes !== 5'd3 ||
            cap_first !== 1'b1 || cap_last !== 1'b1 || cap_type !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_next: got=%b data=%h bytes=%0d first=%b last=%b type=%b required data=0000000001332211_0 bytes=3 first=1 last=1 type=0",
                     got, cap_data, cap_bytes, cap_first, cap_last, cap_type);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_bytes  = '0;
        in_last   = 1'b0;
        in_type   = 1'b0;
        blk_ready = 1'b0;
        cap_data  = '0;
        cap_bytes = '0;
        cap_first = 1'b0;
        cap_last  = 1'b0;
        cap_type  = 1'b0;
        got       = 1'b0;
        sent      = 1'b0;

        test_reset();
        test_ad_segment();
        test_msg_exact16();
        test_empty_ad();
        test_backpressure();
        test_error();
        test_reset_midblock();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ascon_block_packer.md
# ascon_block_packer

Upstream stage of the Ascon-AEAD128 core data path. It takes a 32-bit word stream of associated data or message bytes and packs it into 128-bit rate blocks with Ascon-AEAD128 padding applied. Each block carries segment markers (first, last), the valid-byte count and the segment type. The controller uses these markers to drive the AD/data block selection and AD-end domain separation, and to truncate the final output block.

## Interface

Parameters:
- None; word width fixed at 32, block width fixed at 128.

Ports:
- clk  input  1  clock; single clock domain, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  block accepts input word this cycle
- in_data  input  32  input bytes; byte j at in_data[8j+7:8j], earliest byte j=0
- in_bytes  input  3  valid bytes in word, 0..4; valid bytes always low-aligned
- in_last  input  1  word is last of segment
- in_type  input  1  0 = associated data, 1 = message data; sampled on first word of segment
- blk_valid  output  1  output block valid
- blk_ready  input  1  consumer accepts block
- blk_data  output  128  packed, padded block
- blk_bytes  output  5  real (unpadded) bytes in block, 0..16
- blk_first  output  1  first block of segment
- blk_last  output  1  last block of segment (contains padding)
- blk_type  output  1  in_type latched for the segment
- err  output  1  sticky protocol-violation flag

## Operation

- Block byte k (k = 0..15) maps to lane L = k/8, where lane 0 = blk_data[127:64] and lane 1 = blk_data[63:0]. Within a lane the byte is little-endian: bits [64*(1-L) + 8*(k%8) +: 8].
- A 5-bit byte counter n holds the accumulated count, 0..16. An accepted word writes its bytes at positions n..n+in_bytes-1, then n += in_bytes.
- FSM states:
  - FILL: in_ready=1, blk_valid=0.
  - EMIT: in_ready=0, blk_valid=1.
  - PAD: in_ready=0, blk_valid=1.
- FILL transitions on an accepted word:
  - n reaches 16 and in_last=0 → EMIT with blk_bytes=16, blk_last=0.
  - in_last=1 and final n<16 → write 0x01 at byte n, zero bytes n+1..15; EMIT with blk_bytes=n, blk_last=1.
  - in_last=1 and final n=16 → EMIT full block with blk_last=0, and set pad_pending.
  - Otherwise stay in FILL.
- EMIT on blk_ready:
  - pad_pending=1 → PAD. The buffer loads the padding-only block: byte0=0x01, rest 0, blk_bytes=0, blk_last=1, blk_first=0.
  - pad_pending=0 → FILL. Clear the buffer and n.
  - If the emitted block had blk_last=0, the segment continues.
- PAD on blk_ready → FILL. Clear pad_pending, the buffer and n.
- blk_first=1 on the first block emitted after a segment start (reset, or the previous blk_last handshake). Otherwise 0.
- blk_type latches in_type when the first word of a segment is accepted. It is held constant for the whole segment.
- Empty segment: first word of segment has in_last=1 and in_bytes=0. It produces one block with byte0=0x01, blk_bytes=0, blk_first=1, blk_last=1. For AD the controller skips AD processing when blk_first & blk_last & blk_bytes==0.
- Protocol violations, each setting err=1 on the next cycle:
  - in_bytes>4;
  - in_bytes≠4 with in_last=0.
- After a violation the word is still accepted using min(in_bytes,4). Data content is unspecified until reset. err clears only on reset.

## Timing

- Reset values: in_ready=1, blk_valid=0, blk_data=0, blk_bytes=0, blk_first=0, blk_last=0, blk_type=0, err=0. FSM resets to FILL, with n=0 and pad_pending=0.
- Input handshake: a word is transferred when in_valid & in_ready. Output handshake: a block is transferred when blk_valid & blk_ready.
- blk_valid rises the cycle after the completing word is accepted.
- All outputs are registered. in_ready decodes only from FSM state, so there is no combinational path from blk_ready or in_valid to in_ready.
- While blk_valid=1 and blk_ready=0, all blk_* outputs are held stable.
- Full-block throughput: 4 input cycles + 1 emit cycle = 5 cycles per 16 bytes.
- Reset asserted mid-block discards all partial data and any pending padding. The next accepted word starts a new segment at byte 0.

## Test plan

- AD segment of bytes 0x00..0x13, five 4-byte words, last on word 5, consumer always ready. Required:
  - block 1: lane0=0x0706050403020100, lane1=0x0F0E0D0C0B0A0908, blk_bytes=16, first=1, last=0, type=0;
  - block 2: lane0=0x0000000113121110, lane1=0, blk_bytes=4, first=0, last=1.
- Message of exactly 16 bytes. Required:
  - full block with last=0;
  - then padding block with lane0=0x0000000000000001, lane1=0, blk_bytes=0, first=0, last=1, type=1.
- Empty AD: one word with in_last=1, in_bytes=0 → one block with byte0=0x01, blk_bytes=0, first=1, last=1.
- Backpressure: blk_ready=0 for 10 cycles with a block pending. Required:
  - blk_valid=1 and blk_* stable throughout, in_ready=0;
  - on release, exactly one transfer, then in_ready=1 on the next cycle.
- Non-last word with in_bytes=2 → err=1 the next cycle, remaining 1 through later traffic until rst_n is asserted.
- Reset after 2 accepted words. Required:
  - outputs return to reset values;
  - a following 3-byte last-only segment yields blk_bytes=3 with padding 0x01 at byte 3 and first=1.
